// File: rtl/ram_mbist.sv
// ram_mbist: March C- built-in self-test controller for a single-port 32-bit SRAM
module ram_mbist #(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] BG        = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [15:0]       fail_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [31:0]       fail_rdata,
  output logic              ram_req,
  output logic [31:0]       ram_addr,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST = '1;
  state_t state, state_nx;
  logic [2:0] elem, elem_nx, chk_elem;
  logic [ADDR_W-1:0] idx, idx_nx, chk_idx;
  logic ph, ph_nx, down, rw, last, go, we_nx, req_nx, chk_v, mis;
  logic [31:0] addr_nx, wdata_nx, rd_exp, chk_exp;
  // march sequencer: current op is (elem, idx, ph); ph=1 is the write half of an r,w pair
  always_comb begin
    go = start && (state == IDLE || state == DONE);
    down = elem == 3'd3 || elem == 3'd4;
    rw = elem != 3'd0 && elem != 3'd5;
    last = down ? idx == '0 : idx == LAST;
    rd_exp = (elem == 3'd2 || elem == 3'd4) ? ~BG : BG;
    state_nx = state;
    elem_nx = elem;
    idx_nx = idx;
    ph_nx = ph;
    if (go) begin
      state_nx = RUN;
      elem_nx = '0;
      idx_nx = '0;
      ph_nx = 1'b0;
    end else if (state == RUN) begin
      if (rw && !ph) ph_nx = 1'b1;
      else if (!last) begin
        ph_nx = 1'b0;
        idx_nx = down ? idx - 1'b1 : idx + 1'b1;
      end else if (elem == 3'd5) state_nx = FLUSH;
      else begin
        ph_nx = 1'b0;
        elem_nx = elem + 3'd1;
        idx_nx = (elem == 3'd2 || elem == 3'd3) ? LAST : '0;
      end
    end else if (state == FLUSH) state_nx = DONE;
    req_nx = state_nx == RUN;
    we_nx = req_nx && (elem_nx == 3'd0 || ph_nx);
    addr_nx = req_nx ? BASE_ADDR + 32'({idx_nx, 2'b00}) : '0;
    wdata_nx = we_nx ? ((elem_nx == 3'd1 || elem_nx == 3'd3) ? ~BG : BG) : '0;
    mis = chk_v && ram_rdata != chk_exp;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // registered RAM request, one-cycle-delayed read check and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      {elem, idx, ph, chk_v, chk_exp, chk_idx, chk_elem} <= '0;
      {ram_req, ram_we, ram_be, ram_addr, ram_wdata} <= '0;
      {busy, done, fail, fail_cnt, fail_addr, fail_elem, fail_rdata} <= '0;
    end else begin
      elem <= elem_nx;
      idx <= idx_nx;
      ph <= ph_nx;
      ram_req <= req_nx;
      ram_we <= we_nx;
      ram_be <= req_nx ? 4'hF : 4'h0;
      ram_addr <= addr_nx;
      ram_wdata <= wdata_nx;
      chk_v <= ram_req && !ram_we;
      chk_exp <= rd_exp;
      chk_idx <= idx;
      chk_elem <= elem;
      busy <= state_nx == RUN || state_nx == FLUSH;
      done <= state_nx == DONE;
      if (go) {fail, fail_cnt, fail_addr, fail_elem, fail_rdata} <= '0;
      else if (mis) begin
        fail_cnt <= fail_cnt + {15'd0, fail_cnt != 16'hFFFF};
        if (!fail) begin
          fail <= 1'b1;
          fail_addr <= chk_idx;
          fail_elem <= chk_elem;
          fail_rdata <= ram_rdata;
        end
      end
    end
  end
endmodule

// File: tb/tb_ram_mbist.sv
// tb_ram_mbist: scoreboarded March C- trace and result checks against behavioural RAM models
module tb_ram_mbist;
  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wd;} op_t;
  logic clk = 0, rst, start_a, start_b, stuck, corrupt, sel;
  logic a_busy, a_done, a_fail, a_req, a_we, b_busy, b_done, b_fail, b_req, b_we;
  logic [15:0] a_cnt, b_cnt;
  logic [1:0] a_faddr, b_faddr;
  logic [2:0] a_felem, b_felem;
  logic [31:0] a_frd, b_frd, a_addr, b_addr, a_wd, b_wd, a_rd, b_rd;
  logic [3:0] a_be, b_be;
  logic [31:0] mem_a [4];
  logic [31:0] mem_b [4];
  logic m_busy, m_done, m_fail, m_req, m_we;
  logic [15:0] m_cnt;
  logic [1:0] m_faddr;
  logic [2:0] m_felem;
  logic [31:0] m_frd, m_addr, m_wd;
  logic [3:0] m_be;
  op_t q[$];
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  ram_mbist #(.ADDR_W(2)) dut_a (.clk(clk), .rst(rst), .start(start_a), .busy(a_busy), .done(a_done),
    .fail(a_fail), .fail_cnt(a_cnt), .fail_addr(a_faddr), .fail_elem(a_felem), .fail_rdata(a_frd),
    .ram_req(a_req), .ram_addr(a_addr), .ram_we(a_we), .ram_be(a_be), .ram_wdata(a_wd), .ram_rdata(a_rd));
  ram_mbist #(.ADDR_W(2), .BG(32'h5555_5555)) dut_b (.clk(clk), .rst(rst), .start(start_b), .busy(b_busy),
    .done(b_done), .fail(b_fail), .fail_cnt(b_cnt), .fail_addr(b_faddr), .fail_elem(b_felem),
    .fail_rdata(b_frd), .ram_req(b_req), .ram_addr(b_addr), .ram_we(b_we), .ram_be(b_be),
    .ram_wdata(b_wd), .ram_rdata(b_rd));
  // RAM A: optional bit 5 of word 2 stuck at 1
  always @(posedge clk)
    if (a_req) begin
      if (a_we) mem_a[a_addr[3:2]] <= a_wd;
      else a_rd <= mem_a[a_addr[3:2]] | ((stuck && a_addr[3:2] == 2'd2) ? 32'h20 : 32'h0);
    end
  // RAM B: optional corruption of word 3 when it holds AAAA_AAAA
  always @(posedge clk)
    if (b_req) begin
      if (b_we) mem_b[b_addr[3:2]] <= b_wd;
      else b_rd <= (corrupt && b_addr[3:2] == 2'd3 && mem_b[3] == 32'hAAAA_AAAA) ? 32'hAAAA_AAAB : mem_b[b_addr[3:2]];
    end
  assign {m_busy, m_done, m_fail, m_req, m_we} = sel ? {b_busy, b_done, b_fail, b_req, b_we} : {a_busy, a_done, a_fail, a_req, a_we};
  assign {m_cnt, m_faddr, m_felem, m_frd} = sel ? {b_cnt, b_faddr, b_felem, b_frd} : {a_cnt, a_faddr, a_felem, a_frd};
  assign {m_addr, m_wd, m_be} = sel ? {b_addr, b_wd, b_be} : {a_addr, a_wd, a_be};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic gen(input logic [31:0] bg);
    for (int e = 0; e < 6; e++)
      for (int k = 0; k < 4; k++) begin
        int w;
        w = (e == 3 || e == 4) ? 3 - k : k;
        if (e != 0) q.push_back('{1'b0, 32'(w * 4), 32'h0});
        if (e != 5) q.push_back('{1'b1, 32'(w * 4), (e == 1 || e == 3) ? ~bg : bg});
      end
  endtask
  task automatic run(input logic s, input int stray, input int rstc, input logic [31:0] bg,
                     input logic ef, input logic [15:0] ecnt, input logic [1:0] eaddr,
                     input logic [2:0] eelem, input logic [31:0] erd);
    op_t o;
    sel = s;
    gen(bg);
    @(posedge clk);
    #1 if (s) start_b = 1; else start_a = 1;
    @(posedge clk);
    #1 start_a = 0; start_b = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      o = q.pop_front();
      if (c == 1) begin
        chk("clr_done", m_done, 0);
        chk("clr_fail", m_fail, 0);
        chk("clr_cnt", m_cnt, 0);
        chk("busy_run", m_busy, 1);
      end
      chk("req", m_req, 1);
      chk("be", m_be, 4'hF);
      chk("we", m_we, o.we);
      chk("addr", m_addr, o.addr);
      if (o.we) chk("wdata", m_wd, o.wd);
      if (!s && c == 21) chk("m3_rd_addr", m_addr, 32'h0C);
      if (!s && c == 22) chk("m3_wr_data", m_wd, 32'hFFFF_FFFF);
      if (!s && c == 23) chk("m3_rd2_addr", m_addr, 32'h08);
      if (!s && c == 36) chk("m4_last_wr", {m_addr[3:0], m_wd[27:0]}, 32'h0);
      if (s && c == 1) chk("bg_m0_wd", m_wd, 32'h5555_5555);
      if (s && c == 6) chk("bg_m1_wd", m_wd, 32'hAAAA_AAAA);
      if (c == stray) start_a = 1;
      if (c == stray + 1) start_a = 0;
      if (c == rstc) begin
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rst_req", m_req, 0);
        chk("rst_busy", m_busy, 0);
        chk("rst_done", m_done, 0);
        chk("rst_cnt", m_cnt, 0);
        q.delete();
        return;
      end
    end
    @(negedge clk);
    chk("c41_req", m_req, 0);
    chk("c41_busy", m_busy, 1);
    chk("c41_done", m_done, 0);
    @(negedge clk);
    chk("c42_done", m_done, 1);
    chk("c42_busy", m_busy, 0);
    chk("fail", m_fail, ef);
    chk("fail_cnt", m_cnt, ecnt);
    if (ef) begin
      chk("fail_addr", m_faddr, eaddr);
      chk("fail_elem", m_felem, eelem);
      chk("fail_rdata", m_frd, erd);
    end
    repeat (3) @(negedge clk);
    chk("done_hold", m_done, 1);
    chk("idle_req", m_req, 0);
  endtask
  initial begin
    rst = 1; start_a = 0; start_b = 0; stuck = 0; corrupt = 0; sel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst0_req", a_req, 0);
    chk("rst0_out", {a_busy, a_done, a_fail, a_we, a_be}, 0);
    chk("rst0_cnt", a_cnt, 0);
    chk("rst0_addr", a_addr, 0);
    chk("rst0_wd", a_wd, 0);
    rst = 0;
    run(0, 0, 0, 32'h0, 0, 16'd0, 2'd0, 3'd0, 32'h0);
    stuck = 1;
    run(0, 0, 0, 32'h0, 1, 16'd3, 2'd2, 3'd1, 32'h0000_0020);
    stuck = 0;
    run(0, 15, 0, 32'h0, 0, 16'd0, 2'd0, 3'd0, 32'h0);
    run(0, 0, 17, 32'h0, 0, 16'd0, 2'd0, 3'd0, 32'h0);
    run(0, 0, 0, 32'h0, 0, 16'd0, 2'd0, 3'd0, 32'h0);
    corrupt = 1;
    run(1, 0, 0, 32'h5555_5555, 1, 16'd2, 2'd3, 3'd2, 32'hAAAA_AAAB);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ram_mbist.md
Name: ram_mbist

Overview:
- March C- built-in self-test controller for one single-port 32-bit SRAM macro.
- Acts as the initiator on the RAM request interface: drives req/addr/we/be/wdata and checks rdata.
- Sits in front of the RAM's bus-side mux. SoC test logic starts it and reads the pass/fail result.
- Tests the whole array at one operation per cycle.

Parameters:
- ADDR_W, 12, word-address width; number of words N = 2**ADDR_W.
- BASE_ADDR, 32'h0000_0000, byte address of word 0, driven on ram_addr.
- BG, 32'h0000_0000, data background. "0" = BG, "1" = ~BG.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  single-cycle pulse that launches a test
- busy  out  1  test in progress
- done  out  1  result valid; held until next start or rst
- fail  out  1  at least one miscompare seen
- fail_cnt  out  16  number of miscompares, saturates at 16'hFFFF
- fail_addr  out  ADDR_W  word index of the first miscompare
- fail_elem  out  3  march element of the first miscompare (0..5)
- fail_rdata  out  32  rdata captured at the first miscompare
- ram_req  out  1  RAM request, active-high
- ram_addr  out  32  byte address = BASE_ADDR + {idx, 2'b00}
- ram_we  out  1  1 = write, 0 = read
- ram_be  out  4  constant 4'hF while ram_req=1; 4'h0 otherwise
- ram_wdata  out  32  write data
- ram_rdata  in  32  RAM read data; valid the cycle after a read request

Behaviour:
- All ram_* outputs and all status outputs are registered.
- Reset: the edge with rst=1 forces every output to 0, FSM to IDLE.
  - Reset overrides everything, including mid-test.
  - ram_req is 0 in the cycle after that edge.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE/DONE → RUN when start=1:
  - clears fail, fail_cnt, fail_addr, fail_elem, fail_rdata and done;
  - sets busy=1.
- start is ignored while busy=1.
- March elements, executed in order, 1 op per cycle, no gaps:
  - M0 up(w0)
  - M1 up(r0,w1)
  - M2 up(r1,w0)
  - M3 down(r0,w1)
  - M4 down(r1,w0)
  - M5 up(r0)
- Address order:
  - "up" runs idx 0..N-1; "down" runs N-1..0.
  - The index counter reloads at each element boundary. It never relies on wrap-around.
- For r,w elements, each address gets the read in one cycle and the write in the next, before moving to the next address.
- Total request cycles: 10N. ram_req stays high for exactly 10N consecutive cycles; cycle 1 is the cycle after start is sampled.
- Read check:
  - An expected value and valid flag are pipelined one cycle behind each read request.
  - ram_rdata is compared against the expected value in the following cycle.
- On a miscompare:
  - fail_cnt increments, saturating.
  - On the first miscompare only: fail=1, and fail_addr/fail_elem/fail_rdata are latched.
  - The test always runs to completion.
- After the last M5 read (cycle 10N):
  - FLUSH (cycle 10N+1) samples the final rdata.
  - DONE is entered with done=1 and busy=0 in cycle 10N+2.
  - Results hold until the next start or rst.
- A miscompare on the final read is counted before done rises.
- ram_we, ram_addr and ram_wdata are don't-care when ram_req=0. They must still hold the reset value (0) while in IDLE.

Test Plan:
1. ADDR_W=2, ideal RAM model, start pulse:
   - ram_req high for exactly 40 consecutive cycles;
   - done=1 in cycle 42;
   - fail=0, fail_cnt=0, busy low from cycle 42.
2. Same config, trace M3:
   - first op is read ram_addr=0x0C, then write 0x0C with wdata=32'hFFFF_FFFF;
   - then read 0x08;
   - last M4 write is addr 0x00, wdata 32'h0.
3. Word 2, bit 5 stuck-at-1:
   - fail=1, fail_elem=1, fail_addr=2, fail_rdata=32'h0000_0020;
   - fail_cnt=3 (M1, M3 and M5 r0 reads).
4. Start handling:
   - start pulse in cycle 15 has no effect on the sequence or on done timing;
   - a start pulse after done clears fail/fail_cnt/done and reruns the full 40 cycles.
5. rst=1 at cycle 17:
   - next cycle ram_req=0, busy=0, done=0, fail_cnt=0;
   - a subsequent start gives a clean full run as in scenario 1.
6. BG=32'h5555_5555:
   - M0 writes 5555_5555, M1 writes AAAA_AAAA;
   - with an injected corruption, 32'hAAAA_AAAB read at word 3 in M2 gives fail_elem=2, fail_addr=3, fail_rdata=32'hAAAA_AAAB.
